// File: rtl/ppu_mode_sequencer.sv
// ppu_mode_sequencer
// Sequences reconfiguration of the pixel-processing pipe (demux, deblur,
// gamma, scaler) when the N64 video mode or the user video config changes.
// A new request must be stable for a full frame. It is then applied on a
// frame boundary, with the output blanked and the scaler flushed. A VCLK
// watchdog stands in for frame starts when video sync is lost, so a pending
// change still completes.

module ppu_mode_sequencer #(
   parameter int CFG_W         = 16,
   parameter int FLUSH_FRAMES  = 2,
   parameter int SETTLE_FRAMES = 1,
   parameter int WDOG_W        = 20
) (
   input  logic             VCLK,
   input  logic             nRST,
   input  logic             nVDSYNC,
   input  logic             nVSYNC_i,
   input  logic [1:0]       vinfo_i,
   input  logic [CFG_W-1:0] cfg_i,
   output logic [1:0]       vinfo_o,
   output logic [CFG_W-1:0] cfg_o,
   output logic             blank_o,
   output logic             nscaler_en_o,
   output logic             busy_o,
   output logic [7:0]       chg_cnt_o
);

   localparam int         REQ_W      = CFG_W + 2;
   localparam logic [3:0] FLUSH_CNT  = 4'(FLUSH_FRAMES);
   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_FRAMES);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_ARM,
      ST_FLUSH,
      ST_SETTLE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         fc;
   logic [3:0]         fc_nxt;
   logic [3:0]         fc_inc;
   logic [REQ_W-1:0]   snap;
   logic [REQ_W-1:0]   snap_nxt;
   logic [REQ_W-1:0]   applied;
   logic [REQ_W-1:0]   applied_nxt;
   logic [REQ_W-1:0]   request;
   logic [7:0]         chg_cnt_nxt;
   logic [WDOG_W-1:0]  wdog;
   logic               vsync_prev;
   logic               real_fs;
   logic               wd_fs;
   logic               fs;
   logic               mismatch;
   logic               blank_nxt;
   logic               nscaler_en_nxt;
   logic               busy_nxt;

   assign request  = {vinfo_i, cfg_i};
   assign mismatch = (request != applied);
   assign fc_inc   = fc + 4'd1;

   // A frame starts on a falling vsync seen in a sample cycle, or when the
   // watchdog runs out while a change is pending (lost video).
   assign real_fs = ~nVDSYNC & ~nVSYNC_i & vsync_prev;
   assign wd_fs   = (state != ST_RUN) & (&wdog);
   assign fs      = real_fs | wd_fs;

   assign {vinfo_o, cfg_o} = applied;

   // Next-state, snapshot, frame-count and applied-config decisions
   always_comb begin
      state_nxt   = state;
      fc_nxt      = fc;
      snap_nxt    = snap;
      applied_nxt = applied;
      chg_cnt_nxt = chg_cnt_o;
      unique case (state)
         ST_RUN: begin
            if (mismatch) begin
               snap_nxt  = request;
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!mismatch) begin
               state_nxt = ST_RUN;
            end else if (fs) begin
               if (request == snap) begin
                  fc_nxt    = 4'd0;
                  state_nxt = ST_FLUSH;
               end else begin
                  snap_nxt = request;
               end
            end
         end
         ST_FLUSH: begin
            if (fs) begin
               if (fc_inc == FLUSH_CNT) begin
                  applied_nxt = request;
                  if (chg_cnt_o != 8'hFF) begin
                     chg_cnt_nxt = chg_cnt_o + 8'd1;
                  end
                  fc_nxt    = 4'd0;
                  state_nxt = ST_SETTLE;
               end else begin
                  fc_nxt = fc_inc;
               end
            end
         end
         ST_SETTLE: begin
            if (fs) begin
               if (fc_inc == SETTLE_CNT) begin
                  fc_nxt = 4'd0;
                  if (mismatch) begin
                     snap_nxt  = request;
                     state_nxt = ST_ARM;
                  end else begin
                     state_nxt = ST_RUN;
                  end
               end else begin
                  fc_nxt = fc_inc;
               end
            end
         end
         default: state_nxt = ST_FLUSH;
      endcase
      blank_nxt      = (state_nxt == ST_FLUSH) || (state_nxt == ST_SETTLE);
      nscaler_en_nxt = (state_nxt != ST_FLUSH);
      busy_nxt       = (state_nxt != ST_RUN);
   end

   // State, counters, sync history and registered outputs
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         state        <= ST_FLUSH;
         fc           <= 4'd0;
         snap         <= '0;
         applied      <= '0;
         chg_cnt_o    <= 8'd0;
         wdog         <= '0;
         vsync_prev   <= 1'b1;
         blank_o      <= 1'b1;
         nscaler_en_o <= 1'b0;
         busy_o       <= 1'b1;
      end else begin
         state        <= state_nxt;
         fc           <= fc_nxt;
         snap         <= snap_nxt;
         applied      <= applied_nxt;
         chg_cnt_o    <= chg_cnt_nxt;
         blank_o      <= blank_nxt;
         nscaler_en_o <= nscaler_en_nxt;
         busy_o       <= busy_nxt;
         if (!nVDSYNC) begin
            vsync_prev <= nVSYNC_i;
         end
         if ((state == ST_RUN) || fs) begin
            wdog <= '0;
         end else begin
            wdog <= wdog + WDOG_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb_ppu_mode_sequencer
// Randomized bench for ppu_mode_sequencer. A frame-level reference model
// tracks the pending request, the frames still to wait and the applied
// config, and every output is compared after each rising VCLK.

module tb_ppu_mode_sequencer;

   localparam int CFG_W         = 16;
   localparam int FLUSH_FRAMES  = 2;
   localparam int SETTLE_FRAMES = 1;
   localparam int WDOG_W        = 8;
   localparam int WD_LIMIT      = (1 << WDOG_W) - 1;

   localparam int P_RUN    = 0;
   localparam int P_ARM    = 1;
   localparam int P_FLUSH  = 2;
   localparam int P_SETTLE = 3;

   logic             VCLK = 1'b0;
   logic             nRST;
   logic             nVDSYNC;
   logic             nVSYNC_i;
   logic [1:0]       vinfo_i;
   logic [CFG_W-1:0] cfg_i;
   logic [1:0]       vinfo_o;
   logic [CFG_W-1:0] cfg_o;
   logic             blank_o;
   logic             nscaler_en_o;
   logic             busy_o;
   logic [7:0]       chg_cnt_o;

   int checkCount = 0;
   int errCount   = 0;

   // Reference model
   int               mPhase;
   int               mLeft;
   int               mIdle;
   int               mCount;
   int               mTotal;
   logic [17:0]      mApplied;
   logic [17:0]      mSnap;
   bit               mPrevVs;

   // Stimulus state
   int               framePos;
   int               frameLen;
   int               frameLo;
   int               frameHi;
   bit               holdHigh;
   int               stimMode;
   int               waited;
   logic [CFG_W-1:0] wdCfg;

   // Free-running pixel clock
   always #5 VCLK = ~VCLK;

   ppu_mode_sequencer #(
      .CFG_W(CFG_W),
      .FLUSH_FRAMES(FLUSH_FRAMES),
      .SETTLE_FRAMES(SETTLE_FRAMES),
      .WDOG_W(WDOG_W)
   ) dut (
      .VCLK(VCLK),
      .nRST(nRST),
      .nVDSYNC(nVDSYNC),
      .nVSYNC_i(nVSYNC_i),
      .vinfo_i(vinfo_i),
      .cfg_i(cfg_i),
      .vinfo_o(vinfo_o),
      .cfg_o(cfg_o),
      .blank_o(blank_o),
      .nscaler_en_o(nscaler_en_o),
      .busy_o(busy_o),
      .chg_cnt_o(chg_cnt_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic finishTest();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
      $finish;
   endtask

   // One rising edge of the model, using the inputs the DUT just sampled
   task automatic modelStep();
      logic [17:0] req;
      bit          isFs;
      if (!nRST) begin
         mPhase   = P_FLUSH;
         mLeft    = FLUSH_FRAMES;
         mIdle    = 0;
         mCount   = 0;
         mTotal   = 0;
         mApplied = '0;
         mSnap    = '0;
         mPrevVs  = 1'b1;
         return;
      end
      req  = {vinfo_i, cfg_i};
      isFs = (!nVDSYNC && !nVSYNC_i && mPrevVs) || (mPhase != P_RUN && mIdle == WD_LIMIT);
      if (!nVDSYNC) mPrevVs = nVSYNC_i;
      mIdle = (mPhase == P_RUN || isFs) ? 0 : mIdle + 1;
      if (mPhase == P_RUN) begin
         if (req != mApplied) begin
            mSnap  = req;
            mPhase = P_ARM;
         end
      end else if (mPhase == P_ARM) begin
         if (req == mApplied) mPhase = P_RUN;
         else if (isFs) begin
            if (req == mSnap) begin
               mPhase = P_FLUSH;
               mLeft  = FLUSH_FRAMES;
            end else mSnap = req;
         end
      end else if (mPhase == P_FLUSH) begin
         if (isFs) begin
            mLeft--;
            if (mLeft == 0) begin
               mApplied = req;
               mCount   = (mCount < 255) ? mCount + 1 : 255;
               mTotal++;
               mPhase   = P_SETTLE;
               mLeft    = SETTLE_FRAMES;
            end
         end
      end else begin
         if (isFs) begin
            mLeft--;
            if (mLeft == 0) begin
               if (req != mApplied) begin
                  mSnap  = req;
                  mPhase = P_ARM;
               end else mPhase = P_RUN;
            end
         end
      end
   endtask

   // Drive sync strobes and request changes for the next edge
   task automatic applyStimulus();
      bit vsLevel;
      framePos++;
      if (framePos >= frameLen) begin
         framePos = 0;
         frameLen = $urandom_range(frameHi, frameLo);
      end
      vsLevel  = (framePos < 3 && !holdHigh) ? 1'b0 : 1'b1;
      nVDSYNC  = 1'($urandom);
      nVSYNC_i = nVDSYNC ? 1'($urandom) : vsLevel;
      if (stimMode == 1) begin
         if ($urandom_range(99, 0) == 0 || (mPhase == P_ARM && $urandom_range(19, 0) == 0)) begin
            case ($urandom_range(3, 0))
               0: cfg_i = 16'($urandom);
               1: {vinfo_i, cfg_i} = mApplied;
               2: vinfo_i = 2'($urandom);
               default: cfg_i = cfg_i ^ 16'h0001;
            endcase
         end
      end else if (stimMode == 2) begin
         if (mPhase == P_RUN) cfg_i = mApplied[15:0] ^ 16'($urandom_range(65535, 1));
      end
   endtask

   task automatic compareAll();
      checkOutput("blank", 32'(blank_o), 32'(mPhase == P_FLUSH || mPhase == P_SETTLE));
      checkOutput("nscaler_en", 32'(nscaler_en_o), 32'(mPhase != P_FLUSH));
      checkOutput("busy", 32'(busy_o), 32'(mPhase != P_RUN));
      checkOutput("vinfo", 32'(vinfo_o), 32'(mApplied[17:16]));
      checkOutput("cfg", 32'(cfg_o), 32'(mApplied[15:0]));
      checkOutput("chg_cnt", 32'(chg_cnt_o), 32'(mCount));
   endtask

   task automatic tick();
      @(negedge VCLK);
      applyStimulus();
      @(posedge VCLK);
      modelStep();
      #1;
      compareAll();
      if (errCount >= 40) finishTest();
   endtask

   initial begin
      nRST     = 1'b0;
      nVDSYNC  = 1'b1;
      nVSYNC_i = 1'b1;
      vinfo_i  = 2'b01;
      cfg_i    = 16'h00A5;
      framePos = 0;
      frameLen = 100;
      frameLo  = 80;
      frameHi  = 120;
      holdHigh = 1'b0;
      stimMode = 0;
      repeat (3) tick();
      nRST = 1'b1;

      // Reset release with a stable request: first change applies after two frames
      $display("[TB] reset release with stable request");
      repeat (800) tick();
      checkOutput("p1_cfg", 32'(cfg_o), 32'h00A5);
      checkOutput("p1_vinfo", 32'(vinfo_o), 32'h1);
      checkOutput("p1_cnt", 32'(chg_cnt_o), 32'd1);
      checkOutput("p1_busy", 32'(busy_o), 32'd0);

      // Random request changes, reverts and re-changes while armed
      $display("[TB] random request changes");
      stimMode = 1;
      frameLo  = 30;
      frameHi  = 120;
      repeat (6000) tick();

      // Lost video: watchdog frame starts must still complete a change
      $display("[TB] watchdog frame starts");
      stimMode = 0;
      holdHigh = 1'b1;
      wdCfg    = mApplied[15:0] ^ 16'hBEEF;
      cfg_i    = wdCfg;
      repeat (2000) tick();
      checkOutput("wd_cfg", 32'(cfg_o), 32'(wdCfg));
      checkOutput("wd_busy", 32'(busy_o), 32'd0);

      // Reset pulse while settling
      $display("[TB] reset during settle");
      holdHigh = 1'b0;
      frameLo  = 30;
      frameHi  = 60;
      cfg_i    = cfg_i ^ 16'h00F0;
      waited   = 0;
      while (mPhase != P_SETTLE && waited < 3000) begin
         tick();
         waited++;
      end
      checkOutput("settle_reached", 32'(blank_o & nscaler_en_o), 32'd1);
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      checkOutput("rst_cfg", 32'(cfg_o), 32'd0);
      checkOutput("rst_cnt", 32'(chg_cnt_o), 32'd0);
      checkOutput("rst_blank", 32'(blank_o), 32'd1);
      checkOutput("rst_nscaler", 32'(nscaler_en_o), 32'd0);

      // Many back-to-back reconfigurations: counter must saturate
      $display("[TB] counter saturation");
      stimMode = 2;
      frameLo  = 6;
      frameHi  = 12;
      waited   = 0;
      while (mTotal < 300 && waited < 40000) begin
         tick();
         waited++;
      end
      checkOutput("sat_cnt", 32'(chg_cnt_o), 32'd255);
      stimMode = 0;
      repeat (50) tick();
      finishTest();
   end

endmodule
